// File: rtl/multi_timer.sv
// rtl/multi_timer.sv - NCH-channel programmable period timer with periodic/one-shot modes
module multi_timer #(
  parameter int              NCH        = 4,
  parameter int              CNT_W      = 28,
  parameter int              CH_W       = 2,
  parameter logic [CNT_W-1:0] DEF_PERIOD = 28'h2FA_F080
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NCH-1:0]   en,
  input  logic [NCH-1:0]   mode,
  input  logic             wr_en,
  input  logic [CH_W-1:0]  wr_ch,
  input  logic [CNT_W-1:0] wr_period,
  output logic [NCH-1:0]   flg,
  output logic [NCH-1:0]   busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t             state_q  [NCH];
  state_t             state_d  [NCH];
  logic [CNT_W-1:0]   cnt_q    [NCH];
  logic [CNT_W-1:0]   cnt_d    [NCH];
  logic [CNT_W-1:0]   period_q [NCH];
  logic [CNT_W-1:0]   period_d [NCH];
  logic [NCH-1:0]     flg_q;
  logic [NCH-1:0]     flg_d;

  // State register: per-channel state, counter, period and the registered pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        state_q[i]  <= ST_IDLE;
        cnt_q[i]    <= CNT_W'(1);
        period_q[i] <= DEF_PERIOD;
      end
      flg_q <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        state_q[i]  <= state_d[i];
        cnt_q[i]    <= cnt_d[i];
        period_q[i] <= period_d[i];
      end
      flg_q <= flg_d;
    end
  end

  // Next-state logic: count, terminal compare, mode handling and period writes
  always_comb begin
    flg_d = '0;
    for (int i = 0; i < NCH; i++) begin
      state_d[i]  = state_q[i];
      cnt_d[i]    = cnt_q[i];
      period_d[i] = period_q[i];

      // A zero period would never match the >= compare sensibly; treat it as 1.
      // Writes addressed beyond NCH match no channel and are dropped.
      if (wr_en && (wr_ch == CH_W'(i))) begin
        period_d[i] = (wr_period == '0) ? CNT_W'(1) : wr_period;
      end

      case (state_q[i])
        // IDLE holds cnt=1, so its first enabled edge is just the first counting
        // edge of RUN; sharing the branch also makes P=1 pulse on that edge.
        ST_IDLE, ST_RUN: begin
          if (!en[i]) begin
            state_d[i] = ST_IDLE;
            cnt_d[i]   = CNT_W'(1);
          end else if (cnt_q[i] >= period_q[i]) begin
            cnt_d[i]   = CNT_W'(1);
            flg_d[i]   = 1'b1;
            state_d[i] = mode[i] ? ST_DONE : ST_RUN;
          end else begin
            cnt_d[i]   = cnt_q[i] + CNT_W'(1);
            state_d[i] = ST_RUN;
          end
        end
        // One-shot finished: re-arm only after en has been seen low
        ST_DONE: begin
          cnt_d[i] = CNT_W'(1);
          if (!en[i]) begin
            state_d[i] = ST_IDLE;
          end
        end
        default: begin
          state_d[i] = ST_IDLE;
          cnt_d[i]   = CNT_W'(1);
        end
      endcase
    end
  end

  // Output logic: registered pulse and RUN-state busy flag
  always_comb begin
    flg = flg_q;
    for (int i = 0; i < NCH; i++) begin
      busy[i] = (state_q[i] == ST_RUN);
    end
  end

endmodule
